// File: rtl/seq_add_ctrl.sv
// Control FSM and serial full-adder stage for an N-bit bit-serial adder.
// It sequences external operand/sum shift registers and captures {cout, result}.
module seq_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cin,
  input  logic         a0,
  input  logic         b0,
  input  logic [N-1:0] sum_q,
  output logic         ld,
  output logic         sbit,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    CAPT  = 2'd3
  } state_e;

  state_e         state_q;
  logic           carry_q;
  logic           carry_d;
  logic [CW-1:0]  cnt_q;
  logic           done_q;
  logic [N-1:0]   result_q;
  logic           cout_q;

  // Serial full adder: sum bit goes straight to the sum register's serial input.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ld      = 1'b0;
    sbit    = 1'b0;
    carry_d = carry_q;
    unique case (state_q)
      LOAD:  ld = 1'b1;
      SHIFT: begin
        sbit    = a0 ^ b0 ^ carry_q;
        carry_d = (a0 & b0) | (a0 & carry_q) | (b0 & carry_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          carry_q <= cin;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= CAPT;
        end
        CAPT: begin
          // After N shifts the sum register holds the sum LSB-aligned.
          result_q <= sum_q;
          cout_q   <= carry_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Bench for seq_add_ctrl: models the external shift registers, keeps an arithmetic
// reference per operation and checks every cycle through a scoreboard monitor.
module tb_seq_add_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin, a0, b0;
  logic         ld, sbit, busy, done, cout;
  logic [N-1:0] sum_q, result;

  logic [N-1:0] a_op, b_op;
  logic [N-1:0] a_sr   = '0;
  logic [N-1:0] b_sr   = '0;
  logic [N-1:0] sum_sr = 8'h5C;

  typedef struct {
    int         done_edge;
    logic [N:0] sum;
  } exp_t;

  exp_t       sb[$];
  int         edge_cnt  = 0;
  int         cur_e     = -1;
  int         idle_from = 0;
  logic [N:0] cur_sum   = '0;
  logic [N:0] held      = '0;
  bit         chk_en    = 1'b0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  seq_add_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cin    (cin),
    .a0     (a0),
    .b0     (b0),
    .sum_q  (sum_q),
    .ld     (ld),
    .sbit   (sbit),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  // External parallel-load / shift-right registers driven by the controller.
  assign a0    = a_sr[0];
  assign b0    = b_sr[0];
  assign sum_q = sum_sr;
  always @(posedge clk) begin
    if (ld) begin
      a_sr <= a_op;
      b_sr <= b_op;
    end else begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
    end
    sum_sr <= {sbit, sum_sr[N-1:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // One clock: apply controls, take the edge, then advance the reference.
  task automatic step(input logic st, input logic r);
    start = st;
    rst   = r;
    @(posedge clk);
    edge_cnt++;
    if (r) begin
      sb.delete();
      cur_e     = -1;
      idle_from = edge_cnt + 1;
      held      = '0;
    end else if (st && edge_cnt >= idle_from) begin
      cur_e     = edge_cnt;
      cur_sum   = {1'b0, a_op} + {1'b0, b_op} + {{N{1'b0}}, cin};
      idle_from = edge_cnt + N + 3;
      sb.push_back('{done_edge: edge_cnt + N + 2, sum: cur_sum});
    end
    #1;
  endtask

  task automatic issue_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    a_op = a;
    b_op = b;
    cin  = c;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic run_check(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           input logic [N:0] exp, input int pulse_at, input string name);
    issue_op(a, b, c);
    for (int i = 0; i < N + 1; i++) step(i == pulse_at, 1'b0);
    check(name, {cout, result}, exp);
    check({name, "_done"}, done, 1);
  endtask

  // Monitor: per-cycle control outputs plus scoreboard pop on done.
  always @(negedge clk) begin : monitor
    int   k;
    logic exp_busy, exp_ld, exp_sbit, exp_done;
    exp_t e;
    if (chk_en) begin
      k        = edge_cnt;
      exp_busy = (cur_e >= 0) && (k >= cur_e) && (k <= cur_e + N + 1);
      exp_ld   = (cur_e >= 0) && (k == cur_e);
      exp_sbit = 1'b0;
      if (cur_e >= 0 && k >= cur_e + 1 && k <= cur_e + N) exp_sbit = cur_sum[k - cur_e - 1];
      check("busy", busy, exp_busy);
      check("ld", ld, exp_ld);
      check("sbit", sbit, exp_sbit);
      exp_done = (sb.size() > 0) && (sb[0].done_edge == k);
      check("done", done, exp_done);
      if (exp_done) begin
        e    = sb.pop_front();
        held = e.sum;
      end
      check("result", {cout, result}, held);
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    cin   = 1'b0;
    a_op  = '0;
    b_op  = '0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_outs", {ld, sbit, busy, done, cout, result}, 0);
    chk_en = 1'b1;
    step(1'b0, 1'b0);

    run_check(8'h5A, 8'h3C, 1'b0, 9'h096, -1, "basic");
    run_check(8'hFF, 8'h01, 1'b0, 9'h100, -1, "wrap");
    run_check(8'hFF, 8'hFF, 1'b1, 9'h1FF, -1, "all_ones_cin");
    run_check(8'h00, 8'h00, 1'b1, 9'h001, -1, "cin_only");

    // Abort at SHIFT cnt=3, then a clean operation.
    issue_op(8'hA7, 8'h6B, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("abort_busy", busy, 0);
    check("abort_result", {cout, result}, 0);
    check("abort_done", done, 0);
    repeat (N + 4) step(1'b0, 1'b0);
    run_check(8'h12, 8'h34, 1'b0, 9'h046, -1, "after_abort");

    // Start pulsed mid-SHIFT is ignored; start in the done cycle is accepted.
    run_check(8'hC3, 8'h4E, 1'b0, 9'h111, 3, "busy_start");
    run_check(8'h80, 8'h80, 1'b1, 9'h101, -1, "back_to_back");

    for (int n = 0; n < 1000; n++) begin
      issue_op(N'($urandom), N'($urandom), 1'($urandom));
      for (int i = 0; i < N + 1; i++) step($urandom_range(0, 7) == 0, 1'b0);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
    end

    repeat (4) step(1'b0, 1'b0);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
